if_fetch_queue: RTL and testbench
=================================

// Module: if_fetch_queue
// PURPOSE
//  Next-gen instruction fetch stage. It owns the fetch PC and issues sequential instruction reads.
//  Returned instructions are buffered in a DEPTH-entry in-order queue, so memory latency is decoupled
//  from IF/ID consumption. Branch/jump redirects flush the queue. Sits between imem port and ID stage.
// PARAMETERS
//  DEPTH     4             queue entries; power of 2, >=2
//  RESET_PC  32'h0000_0000 fetch PC after reset (low 2 bits must be 0)
// PORTS
//  clk            in   1                    single clock, all state on posedge
//  rst_n          in   1                    reset: synchronous, active-low
//  en             in   1                    fetch enable; 0 = issue no new reads
//  redirect_en    in   1                    redirect request (branch/jump/trap)
//  redirect_pc    in   rv32i::addr_t        redirect target
//  next_rdy       in   1                    ID accepts if_id this cycle (pop)
//  inst_read_rsp  in   sys::mem_read_rsp_t  .done/.valid/.data from imem
//  inst_read_req  out  sys::mem_read_req_t  .addr/.mask/.en to imem
//  if_id          out  core::if_id_t        queue head: .pc/.inst/.valid
//  rdy            out  1                    queue non-empty (== if_id.valid)
// BEHAVIOUR
//  Clocking and reset:
//  - One clock. Reset is synchronous and active-low.
//  - Edge with rst_n=0: fetch_pc<=RESET_PC, queue empty, pending/discard flags cleared.
//  - While rst_n=0: inst_read_req.en=0, if_id.valid=0, rdy=0.
//  - if_id.pc/.inst are don't-care when .valid=0.
//  Read request:
//  - inst_read_req.addr=fetch_pc; mask=all ones (inst_width/byte_width bits).
//  - inst_read_req.en = rst_n && en && !redirect_en && count<DEPTH && !discard.
//    count is the registered occupancy; a same-cycle pop does NOT free a slot (no comb path next_rdy->req).
//  - A request is held (addr stable) until a cycle with inst_read_rsp.done=1; at most 1 outstanding.
//  Response handling (done=1 while req.en=1):
//  - valid=1: push {fetch_pc, data}; fetch_pc <= fetch_pc+4 (wraps mod 2^32).
//  - valid=0 (bus fault): no push; fetch_pc unchanged; same addr re-requested next cycle.
//  - A request dropped mid-flight (en falls or redirect) sets discard.
//    The next done is ignored and clears discard; no request is issued while discard=1.
//  Pop:
//  - if_id = head entry; if_id.valid = count!=0. Pop on next_rdy && if_id.valid.
//  Occupancy:
//  - Push and pop in the same cycle: count unchanged. Legal at count==DEPTH only if the push was
//    requested at count<DEPTH (cannot occur by the rule above).
//  - Empty: no pop; next_rdy ignored.
//  Redirect:
//  - redirect_en=1 has priority over push/pop/reset-free state.
//  - Next edge: queue emptied; fetch_pc <= {redirect_pc[31:2],2'b00}; response in that cycle dropped.
//  - discard set if a request was pending and not done that cycle.
//  - Redirect and pop in the same cycle: the popped entry is still consumed by ID that cycle.
//  - Back-to-back redirects: the last one wins.
//  Latency:
//  - 0-wait imem: first if_id.valid 2 cycles after rst_n rises (1 to fetch+push, visible next cycle).
//  - Steady state: 1 instr/cycle.
//  - Reset mid-operation: the rst_n=0 edge discards everything, including in-flight reads.
// STRUCTURE
//  - Package core: add fetch_entry_t {addr_t pc; inst_t inst;}; if_id_t reused unchanged.
//  - Sub-module if_inst_fifo #(DEPTH, type T=core::fetch_entry_t):
//    sync FIFO, push/pop/flush, count, rst_n.
//  - Top holds fetch_pc, pending/discard flags and request logic.
// TESTING
//  1. Reset, RESET_PC=0x100, 0-wait imem, next_rdy=1 -> if_id.pc 0x100,0x104,0x108... 1/cycle, valid from 2nd cycle.
//  2. next_rdy=0 for 10 cycles -> exactly DEPTH=4 pushes then req.en=0.
//     next_rdy=1 -> pcs drain in order, no gaps or duplicates.
//  3. Pending read at 0x200, done delayed 3 cycles; redirect to 0x403 -> queue empty, stale 0x200 data dropped,
//     next req addr 0x400, first if_id.pc=0x400.
//  4. Response at 0x10 returns valid=0 once -> addr 0x10 re-requested; only one entry with pc 0x10 emitted.
//  5. fetch_pc=0xFFFF_FFFC -> next request addr 0x0000_0000.
//  6. rst_n=0 for 1 cycle while queue holds 3 entries and a read is pending -> if_id.valid=0 next cycle,
//     restart at RESET_PC, late done ignored.

Source files
------------

// File: rtl/if_fetch_queue_pkg.sv
// Shared types for the instruction fetch queue: address/instruction words,
// imem request/response bundles, queue entries and the IF/ID stage record.
package if_fetch_queue_pkg;

    localparam int XLEN   = 32;
    localparam int INST_W = 32;
    localparam int BYTE_W = 8;
    localparam int MASK_W = INST_W / BYTE_W;

    typedef logic [XLEN-1:0]   addr_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        addr_t             addr;
        logic [MASK_W-1:0] mask;
        logic              en;
    } mem_read_req_t;

    typedef struct packed {
        logic  done;
        logic  valid;
        inst_t data;
    } mem_read_rsp_t;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
    } fetch_entry_t;

    typedef struct packed {
        addr_t pc;
        inst_t inst;
        logic  valid;
    } if_id_t;

    // Instructions are word aligned; redirect targets drop their low two bits.
    function automatic addr_t align_pc(addr_t a);
        return a & ~addr_t'(3);
    endfunction

endpackage

// File: rtl/if_inst_fifo.sv
// In-order synchronous FIFO holding fetched instructions. Flush empties it
// in one cycle; push when full and pop when empty are ignored.
module if_inst_fifo
    import if_fetch_queue_pkg::*;
#(
    parameter int  DEPTH = 4,
    parameter type T     = fetch_entry_t
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     i_flush,
    input  logic                     i_push,
    input  T                         i_data,
    input  logic                     i_pop,
    output T                         o_head,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    T                r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [CW-1:0]   r_count;
    logic            w_full;
    logic            w_push_ok;
    logic            w_pop_ok;

    assign w_full    = (r_count == DEPTH_CNT);
    assign o_empty   = (r_count == '0);
    assign w_push_ok = i_push && !w_full;
    assign w_pop_ok  = i_pop && !o_empty;
    assign o_head    = r_mem[r_rd_ptr];
    assign o_count   = r_count;

    // Pointer and occupancy bookkeeping; reset and flush both empty the queue.
    always_ff @(posedge clk) begin
        if (!rst_n || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop_ok)  r_rd_ptr <= r_rd_ptr + 1'b1;
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // Entry storage carries no reset; occupancy alone decides what is live.
    always_ff @(posedge clk) begin
        if (w_push_ok) r_mem[r_wr_ptr] <= i_data;
    end

endmodule

// File: rtl/if_fetch_queue.sv
// Instruction fetch stage: owns the fetch PC, issues one sequential imem read
// at a time and buffers returned instructions in an in-order queue feeding ID.
// Redirects flush the queue; a read abandoned mid-flight has its eventual
// response swallowed via the discard flag.
module if_fetch_queue
    import if_fetch_queue_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
)(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          en,
    input  logic          redirect_en,
    input  addr_t         redirect_pc,
    input  logic          next_rdy,
    input  mem_read_rsp_t inst_read_rsp,
    output mem_read_req_t inst_read_req,
    output if_id_t        if_id,
    output logic          rdy
);

    localparam int CW = $clog2(DEPTH) + 1;
    localparam logic [CW-1:0] DEPTH_CNT = CW'(DEPTH);

    addr_t          r_fetch_pc;
    logic           r_pending;
    logic           r_discard;

    logic [CW-1:0]  w_count;
    logic           w_empty;
    logic           w_valid;
    logic           w_req_en;
    logic           w_push;
    logic           w_pop;
    logic           w_drop;
    fetch_entry_t   w_push_entry;
    fetch_entry_t   w_head;

    // Occupancy is the registered count, so a pop this cycle never opens a
    // slot for a request this cycle (no combinational next_rdy -> req path).
    assign w_req_en = rst_n && en && !redirect_en && (w_count < DEPTH_CNT) && !r_discard;
    assign w_push   = w_req_en && inst_read_rsp.done && inst_read_rsp.valid;
    assign w_valid  = rst_n && !w_empty;
    assign w_pop    = next_rdy && w_valid;
    // An outstanding read loses its request without completing: its later
    // response belongs to an address we no longer want.
    assign w_drop   = r_pending && !inst_read_rsp.done && !w_req_en;

    assign w_push_entry.pc   = r_fetch_pc;
    assign w_push_entry.inst = inst_read_rsp.data;

    if_inst_fifo #(
        .DEPTH (DEPTH),
        .T     (fetch_entry_t)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_flush (redirect_en),
        .i_push  (w_push),
        .i_data  (w_push_entry),
        .i_pop   (w_pop),
        .o_head  (w_head),
        .o_count (w_count),
        .o_empty (w_empty)
    );

    // Fetch PC: redirect wins, otherwise advance past each accepted instruction.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_fetch_pc <= RESET_PC;
        end else if (redirect_en) begin
            r_fetch_pc <= align_pc(redirect_pc);
        end else if (w_push) begin
            r_fetch_pc <= r_fetch_pc + 32'd4;
        end
    end

    // Track the single outstanding read and whether its response must be dropped.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pending <= 1'b0;
            r_discard <= 1'b0;
        end else begin
            r_pending <= w_req_en && !inst_read_rsp.done;
            if (w_drop) begin
                r_discard <= 1'b1;
            end else if (r_discard && inst_read_rsp.done) begin
                r_discard <= 1'b0;
            end
        end
    end

    // Drive the imem request and present the queue head to ID.
    always_comb begin
        inst_read_req      = '0;
        inst_read_req.addr = r_fetch_pc;
        inst_read_req.mask = '1;
        inst_read_req.en   = w_req_en;
        if_id              = '0;
        if_id.pc           = w_head.pc;
        if_id.inst         = w_head.inst;
        if_id.valid        = w_valid;
        rdy                = w_valid;
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed testbench for if_fetch_queue: reset, streaming, backpressure,
// redirect with a stale in-flight read, bus fault retry, PC wrap and
// mid-operation reset.
module tb_if_fetch_queue;
    import if_fetch_queue_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] KEY    = 32'h5A5A_A5A5;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          redirect_en;
    addr_t         redirect_pc;
    logic          next_rdy;
    mem_read_rsp_t inst_read_rsp;
    mem_read_req_t inst_read_req;
    if_id_t        if_id;
    logic          rdy;

    logic          mem_done;
    logic          mem_valid;

    int errors = 0;
    int checks = 0;

    if_fetch_queue #(
        .DEPTH    (4),
        .RESET_PC (RST_PC)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (en),
        .redirect_en   (redirect_en),
        .redirect_pc   (redirect_pc),
        .next_rdy      (next_rdy),
        .inst_read_rsp (inst_read_rsp),
        .inst_read_req (inst_read_req),
        .if_id         (if_id),
        .rdy           (rdy)
    );

    // imem model: instruction word is a fixed scramble of the requested address.
    assign inst_read_rsp.done  = mem_done;
    assign inst_read_rsp.valid = mem_valid;
    assign inst_read_rsp.data  = inst_read_req.addr ^ KEY;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_inst(logic [31:0] a);
        return a ^ KEY;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; en = 1'b1; redirect_en = 1'b0; redirect_pc = '0;
        next_rdy = 1'b1; mem_done = 1'b1; mem_valid = 1'b1;
        tick();
        tick();
        checks++; if (if_id.valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", if_id.valid); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL reset_rdy got=%b exp=0", rdy); end
        checks++; if (inst_read_req.en !== 1'b0) begin errors++; $display("FAIL reset_req_en got=%b exp=0", inst_read_req.en); end
        checks++; if (inst_read_req.addr !== RST_PC) begin errors++; $display("FAIL reset_addr got=%h exp=%h", inst_read_req.addr, RST_PC); end
    endtask

    task automatic test_stream();
        rst_n = 1'b1;
        #1;
        checks++; if (inst_read_req.en !== 1'b1) begin errors++; $display("FAIL stream_first_en got=%b exp=1", inst_read_req.en); end
        checks++; if (inst_read_req.mask !== 4'hF) begin errors++; $display("FAIL stream_mask got=%h exp=f", inst_read_req.mask); end
        checks++; if (if_id.valid !== 1'b0) begin errors++; $display("FAIL stream_first_valid got=%b exp=0", if_id.valid); end
        tick();
        for (int i = 0; i < 5; i++) begin
            checks++; if (if_id.valid !== 1'b1) begin errors++; $display("FAIL stream_valid[%0d] got=%b exp=1", i, if_id.valid); end
            checks++; if (if_id.pc !== RST_PC + 32'(4*i)) begin errors++; $display("FAIL stream_pc[%0d] got=%h exp=%h", i, if_id.pc, RST_PC + 32'(4*i)); end
            checks++; if (if_id.inst !== exp_inst(RST_PC + 32'(4*i))) begin errors++; $display("FAIL stream_inst[%0d] got=%h exp=%h", i, if_id.inst, exp_inst(RST_PC + 32'(4*i))); end
            tick();
        end
    endtask

    task automatic test_backpressure();
        int pushes;
        en = 1'b0;
        tick();
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL bp_drained got=%b exp=0", rdy); end
        en = 1'b1; next_rdy = 1'b0;
        #1;
        pushes = 0;
        for (int i = 0; i < 10; i++) begin
            if (inst_read_req.en) pushes++;
            tick();
        end
        checks++; if (pushes !== 4) begin errors++; $display("FAIL bp_pushes got=%0d exp=4", pushes); end
        checks++; if (inst_read_req.en !== 1'b0) begin errors++; $display("FAIL bp_full_req_en got=%b exp=0", inst_read_req.en); end
        next_rdy = 1'b1;
        for (int i = 0; i < 8; i++) begin
            checks++; if (if_id.valid !== 1'b1) begin errors++; $display("FAIL bp_drain_valid[%0d] got=%b exp=1", i, if_id.valid); end
            checks++; if (if_id.pc !== 32'h118 + 32'(4*i)) begin errors++; $display("FAIL bp_drain_pc[%0d] got=%h exp=%h", i, if_id.pc, 32'h118 + 32'(4*i)); end
            tick();
        end
    endtask

    task automatic test_redirect();
        redirect_en = 1'b1; redirect_pc = 32'h200; mem_done = 1'b0;
        tick();
        redirect_en = 1'b0;
        #1;
        checks++; if (inst_read_req.en !== 1'b1) begin errors++; $display("FAIL redir_pend_en got=%b exp=1", inst_read_req.en); end
        checks++; if (inst_read_req.addr !== 32'h200) begin errors++; $display("FAIL redir_pend_addr got=%h exp=200", inst_read_req.addr); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL redir_flushed got=%b exp=0", rdy); end
        tick();
        checks++; if (inst_read_req.addr !== 32'h200) begin errors++; $display("FAIL redir_hold_addr got=%h exp=200", inst_read_req.addr); end
        tick();
        redirect_en = 1'b1; redirect_pc = 32'h403;
        tick();
        redirect_en = 1'b0; mem_done = 1'b1;
        #1;
        checks++; if (inst_read_req.en !== 1'b0) begin errors++; $display("FAIL redir_discard_en got=%b exp=0", inst_read_req.en); end
        tick();
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL redir_stale_dropped got=%b exp=0", rdy); end
        checks++; if (inst_read_req.en !== 1'b1) begin errors++; $display("FAIL redir_resume_en got=%b exp=1", inst_read_req.en); end
        checks++; if (inst_read_req.addr !== 32'h400) begin errors++; $display("FAIL redir_new_addr got=%h exp=400", inst_read_req.addr); end
        tick();
        checks++; if (if_id.valid !== 1'b1) begin errors++; $display("FAIL redir_first_valid got=%b exp=1", if_id.valid); end
        checks++; if (if_id.pc !== 32'h400) begin errors++; $display("FAIL redir_first_pc got=%h exp=400", if_id.pc); end
        checks++; if (if_id.inst !== exp_inst(32'h400)) begin errors++; $display("FAIL redir_first_inst got=%h exp=%h", if_id.inst, exp_inst(32'h400)); end
    endtask

    task automatic test_bus_fault();
        redirect_en = 1'b1; redirect_pc = 32'h10;
        tick();
        redirect_en = 1'b0; mem_valid = 1'b0;
        #1;
        checks++; if (inst_read_req.addr !== 32'h10) begin errors++; $display("FAIL fault_addr got=%h exp=10", inst_read_req.addr); end
        tick();
        checks++; if (inst_read_req.addr !== 32'h10) begin errors++; $display("FAIL fault_retry_addr got=%h exp=10", inst_read_req.addr); end
        checks++; if (rdy !== 1'b0) begin errors++; $display("FAIL fault_no_push got=%b exp=0", rdy); end
        mem_valid = 1'b1;
        tick();
        checks++; if (if_id.pc !== 32'h10) begin errors++; $display("FAIL fault_pc0 got=%h exp=10", if_id.pc); end
        tick();
        checks++; if (if_id.pc !== 32'h14) begin errors++; $display("FAIL fault_pc1 got=%h exp=14", if_id.pc); end
    endtask

    task automatic test_wrap();
        redirect_en = 1'b1; redirect_pc = 32'hFFFF_FFFC;
        tick();
        redirect_en = 1'b0;
        #1;
        checks++; if (inst_read_req.addr !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_top_addr got=%h exp=fffffffc", inst_read_req.addr); end
        tick();
        checks++; if (inst_read_req.addr !== 32'h0) begin errors++; $display("FAIL wrap_next_addr got=%h exp=0", inst_read_req.addr); end
        checks++; if (if_id.pc !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_head_pc got=%h exp=fffffffc", if_id.pc); end
        tick();
        checks++; if (if_id.pc !== 32'h0) begin errors++; $display("FAIL wrap_pc0 got=%h exp=0", if_id.pc); end
        checks++; if (if_id.inst !== exp_inst(32'h0)) begin errors++; $display("FAIL wrap_inst0 got=%h exp=%h", if_id.inst, exp_inst(32'h0)); end
    endtask

    task automatic test_reset_mid();
        next_rdy = 1'b0; redirect_en = 1'b1; redirect_pc = 32'h300;
        tick();
        redirect_en = 1'b0;
        tick();
        tick();
        tick();
        mem_done = 1'b0;
        #1;
        checks++; if (inst_read_req.addr !== 32'h30C) begin errors++; $display("FAIL rmid_pend_addr got=%h exp=30c", inst_read_req.addr); end
        tick();
        checks++; if (rdy !== 1'b1) begin errors++; $display("FAIL rmid_held got=%b exp=1", rdy); end
        checks++; if (if_id.pc !== 32'h300) begin errors++; $display("FAIL rmid_head got=%h exp=300", if_id.pc); end
        rst_n = 1'b0; mem_done = 1'b1;
        #1;
        checks++; if (inst_read_req.en !== 1'b0) begin errors++; $display("FAIL rmid_rst_req_en got=%b exp=0", inst_read_req.en); end
        checks++; if (if_id.valid !== 1'b0) begin errors++; $display("FAIL rmid_rst_valid got=%b exp=0", if_id.valid); end
        tick();
        rst_n = 1'b1; mem_done = 1'b0;
        #1;
        checks++; if (if_id.valid !== 1'b0) begin errors++; $display("FAIL rmid_after_valid got=%b exp=0", if_id.valid); end
        checks++; if (inst_read_req.addr !== RST_PC) begin errors++; $display("FAIL rmid_restart_addr got=%h exp=%h", inst_read_req.addr, RST_PC); end
        checks++; if (inst_read_req.en !== 1'b1) begin errors++; $display("FAIL rmid_restart_en got=%b exp=1", inst_read_req.en); end
        next_rdy = 1'b1; mem_done = 1'b1;
        tick();
        checks++; if (if_id.valid !== 1'b1) begin errors++; $display("FAIL rmid_first_valid got=%b exp=1", if_id.valid); end
        checks++; if (if_id.pc !== RST_PC) begin errors++; $display("FAIL rmid_first_pc got=%h exp=%h", if_id.pc, RST_PC); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_stream();
        test_backpressure();
        test_redirect();
        test_bus_fault();
        test_wrap();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
